// File: rtl/fifo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_deserializer
// Purpose  : Packs R consecutive DATA_WIDTH words into one registered wide
//            beat (first word in lane 0) with valid/ready on both sides.
//            Optional macro FIFO_DESER_TIMEOUT_EN adds an idle timeout that
//            flushes a partial group after wait_cycles idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_deserializer #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_RATIO  = 8,
    parameter int CNT_W      = $clog2(MAX_RATIO + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     deserialization_ratio,
`ifdef FIFO_DESER_TIMEOUT_EN
    input  logic [13:0]                     wait_cycles,
`endif
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*MAX_RATIO-1:0] out_data,
    output logic [CNT_W-1:0]                out_count,
    output logic                            busy
);

    localparam int                OUT_W       = DATA_WIDTH * MAX_RATIO;
    localparam logic [15:0]       MAX_RATIO_W = 16'(MAX_RATIO);
    localparam logic [CNT_W-1:0]  MAX_RATIO_C = CNT_W'(MAX_RATIO);
    localparam logic [CNT_W-1:0]  ONE_C       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO_C      = '0;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ratio_q, ratio_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   lanes_q, lanes_d;

    logic [CNT_W-1:0]   w_eff_ratio;
    logic [CNT_W-1:0]   w_group_ratio;
    logic [CNT_W-1:0]   w_cnt_inc;

`ifdef FIFO_DESER_TIMEOUT_EN
    logic [13:0]        idle_q, idle_d;
    logic [13:0]        w_idle_inc;
    assign w_idle_inc = idle_q + 14'd1;
`endif

    // Clamp the requested ratio into 1..MAX_RATIO.
    always_comb begin
        w_eff_ratio = deserialization_ratio[CNT_W-1:0];
        if (deserialization_ratio <= 16'd1) begin
            w_eff_ratio = ONE_C;
        end else if (deserialization_ratio > MAX_RATIO_W) begin
            w_eff_ratio = MAX_RATIO_C;
        end
    end

    // A group's ratio is fixed by whatever is presented with its first word.
    assign w_group_ratio = (cnt_q == ZERO_C) ? w_eff_ratio : ratio_q;
    assign w_cnt_inc     = cnt_q + ONE_C;

    // Outputs come straight from registers; only in_ready sees out_ready.
    assign out_valid = (state_q == DRAIN);
    assign in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
    assign out_data  = lanes_q;
    assign out_count = count_q;
    assign busy      = out_valid | (cnt_q != ZERO_C);

    // Next-state logic: lane fill, beat completion and beat retirement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        count_d = count_q;
        lanes_d = lanes_q;
`ifdef FIFO_DESER_TIMEOUT_EN
        idle_d  = '0;
`endif
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (cnt_q == ZERO_C) begin
                        ratio_d = w_eff_ratio;
                        lanes_d = '0;
                    end
                    lanes_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    if (w_cnt_inc == w_group_ratio) begin
                        state_d = DRAIN;
                        count_d = w_group_ratio;
                        cnt_d   = ZERO_C;
                    end else begin
                        cnt_d   = w_cnt_inc;
                    end
                end
`ifdef FIFO_DESER_TIMEOUT_EN
                else if (cnt_q != ZERO_C) begin
                    // Idle with a partial group: count toward the flush.
                    if ((wait_cycles != 14'd0) && (w_idle_inc >= wait_cycles)) begin
                        state_d = DRAIN;
                        count_d = cnt_q;
                        cnt_d   = ZERO_C;
                    end else begin
                        idle_d  = w_idle_inc;
                    end
                end
`endif
            end
            DRAIN: begin
                if (out_ready) begin
                    lanes_d = '0;
                    count_d = ZERO_C;
                    cnt_d   = ZERO_C;
                    state_d = FILL;
                    if (in_valid) begin
                        // Retire and start the next group in the same cycle.
                        ratio_d = w_eff_ratio;
                        lanes_d[DATA_WIDTH-1:0] = in_data;
                        if (w_eff_ratio == ONE_C) begin
                            state_d = DRAIN;
                            count_d = ONE_C;
                        end else begin
                            cnt_d   = ONE_C;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = ZERO_C;
                count_d = ZERO_C;
                lanes_d = '0;
            end
        endcase
    end

    // State registers; reset discards any held partial group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= ZERO_C;
            ratio_q <= ONE_C;
            count_q <= ZERO_C;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            count_q <= count_d;
            lanes_q <= lanes_d;
        end
    end

`ifdef FIFO_DESER_TIMEOUT_EN
    // Idle counter for the partial-group flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_deserializer.md
Name: fifo_deserializer

Overview:
- Width-adaptation stage between the consumer unit's decoupled valid/ready output and the accelerator's consumer port inside the fifo controller.
- Packs `ratio` consecutive FIFO words into one wide accelerator word, first-arriving word in the least-significant lane.
- Registered output; back-pressure propagates upstream so no word is dropped or duplicated.

Parameters:
- DATA_WIDTH, 64, width of one consumer-side FIFO word (matches fifo_ctrl_pkg::data_width).
- MAX_RATIO, 8, maximum words packed per output beat; output width is DATA_WIDTH*MAX_RATIO.
- CNT_W, $clog2(MAX_RATIO+1), width of the lane counter and out_count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active low.
- deserialization_ratio  input  16  words per output beat; sampled at group start.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  stage accepts the word this cycle.
- in_data  input  DATA_WIDTH  upstream word.
- out_valid  output  1  packed beat valid.
- out_ready  input  1  accelerator accepts the beat.
- out_data  output  DATA_WIDTH*MAX_RATIO  packed beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_count  output  CNT_W  number of valid lanes in out_data.
- busy  output  1  a partial group is held (lane count nonzero, or out_valid high).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - out_valid=0, out_data=0, out_count=0, busy=0, in_ready=1.
  - Internal: lane counter=0, latched ratio=1, state=FILL.
  - Reset asserted mid-group discards all held data; no beat is emitted after reset release.
- Effective ratio R:
  - deserialization_ratio 0 or 1 gives R=1.
  - Values above MAX_RATIO clamp to MAX_RATIO.
  - Otherwise R = deserialization_ratio.
  - R is latched when a word is accepted with the lane counter at 0. Ratio changes mid-group are ignored until the next group.
- States: FILL, DRAIN.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid, in_data is written to lane[cnt] and cnt increments.
  - If the accepted word is the R-th word: next cycle state=DRAIN, out_valid=1, out_count=R, cnt=0.
  - Lanes at or above R are driven zero in out_data.
- DRAIN:
  - out_valid=1, and in_ready=out_ready.
  - out_ready=0: out_data and out_count hold stable, nothing is accepted (valid must not drop without a handshake).
  - out_ready=1 and in_valid=0: beat retires, and next state is FILL with cleared lanes.
  - out_ready=1 and in_valid=1: beat retires and the incoming word becomes lane 0 of the next group; the ratio is re-latched that cycle.
    - If the new R=1, the next state is DRAIN with a new beat, giving one beat per cycle at R=1.
    - Otherwise the next state is FILL with cnt=1.
- Latency and throughput:
  - Last word accepted to out_valid: 1 cycle.
  - Sustained throughput: one input word per cycle when out_ready stays high.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready to in_ready.
- busy = out_valid | (cnt!=0).

Optional Feature:
- Macro FIFO_DESER_TIMEOUT_EN.
- Defined:
  - Adds input port `wait_cycles` (14 bits) and a 14-bit idle counter.
  - In FILL with cnt!=0, the counter increments on each cycle with no accepted word, and resets to 0 on any accept.
  - When the counter reaches wait_cycles (wait_cycles!=0), the partial group is flushed: next cycle DRAIN, out_count=cnt, unfilled lanes zero, counter cleared.
  - wait_cycles=0 disables the timeout.
- Undefined:
  - No wait_cycles port and no counter.
  - Partial groups are held indefinitely until R words arrive.

Test Plan:
- R=4, 8 back-to-back words 0x1..0x8, out_ready=1 → two beats: lanes {1,2,3,4}, then {5,6,7,8}, each 1 cycle after the 4th word; out_count=4; upper lanes 0.
- R=1, continuous 10 words, out_ready=1 → 10 beats on consecutive cycles, lane0=word, out_count=1; R=0 gives identical results.
- R=2, full beat ready, out_ready held 0 for 5 cycles → in_ready=0 and out_data stable for those cycles; release → beat retires and the next word is accepted the same cycle as lane 0.
- R=3 latched, then ratio changed to 2 after the first word → beat still holds 3 words; next group packs 2.
- deserialization_ratio=20 with MAX_RATIO=8 → 8-word beats; reset asserted after 5 words → out_valid=0, busy=0, no stale beat after release.
- With FIFO_DESER_TIMEOUT_EN: R=4, wait_cycles=10, 2 words then idle → partial beat after 10 idle cycles, out_count=2, lanes 2..7 zero.
